lfsr_keystream_gen: RTL and testbench
=====================================

// Module: lfsr_keystream_gen
// PURPOSE
//  Parametrised Fibonacci-LFSR keystream generator for the image-encryption datapath.
//  Loads a key serially by XOR-injecting it into the feedback, then runs WARMUP discard
//  shifts. It then emits OUT_BITS-wide keystream words over a valid/ready handshake for
//  the pixel XOR stage. It detects and repairs the all-zero lockup state.
// PARAMETERS
//  WIDTH     23         LFSR length; state s[WIDTH-1:0], s[0] newest bit
//  TAP_MASK  23'h700080 feedback fb = XOR of s[i] for every i with TAP_MASK[i]=1
//  KEY_LEN   64         key bits accepted in LOAD (>=1)
//  WARMUP    64         discarded shifts after LOAD (0 = skip WARMUP)
//  OUT_BITS  8          keystream word width (1..WIDTH)
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         synchronous, active-high reset
//  start         in   1         pulse: (re)start key load from any state
//  key_bit       in   1         serial key bit
//  key_valid     in   1         key_bit valid this cycle
//  key_ready     out  1         high while FSM==LOAD
//  out_data      out  OUT_BITS  keystream word, first-generated bit in MSB
//  out_valid     out  1         out_data valid; held until accepted
//  out_ready     in   1         consumer accepts when out_valid&&out_ready
//  busy          out  1         FSM != IDLE
//  lockup_fixed  out  1         sticky: zero state was repaired since last start
//  state_o       out  WIDTH     current LFSR state, for debug/verification
// BEHAVIOUR
//  Reset: FSM=IDLE; state, counters, out_data=0; out_valid, lockup_fixed, busy,
//    key_ready=0.
//  Shift step: s <= {s[WIDTH-2:0], fb ^ inj}; inj = key_bit in LOAD, else 0.
//  FSM IDLE -> LOAD on start. In LOAD, state and counters are cleared on entry.
//  LOAD: each cycle with key_valid does one shift with injection and increments key_cnt.
//    After the KEY_LEN-th bit, the next state is WARMUP, or RUN if WARMUP==0.
//    Cycles without key_valid hold state.
//  Lockup repair: on the LOAD exit edge, a post-shift state of 0 is written as 1
//    (s[0]=1) and lockup_fixed is set.
//  WARMUP: one shift per cycle, output discarded; after WARMUP shifts -> RUN.
//  RUN: output bit = s[WIDTH-1] before the shift; bits collect MSB-first into a word.
//    - One shift per cycle, except a stall when bit_cnt==OUT_BITS-1 && out_valid &&
//      !out_ready. A stall holds the state and the collector.
//    - On the OUT_BITS-th shift, the word goes to out_data and out_valid=1 on the next edge.
//    - Accept with no new word: out_valid->0.
//    - Accept and new word on the same edge: out_valid stays 1 with new data.
//    - Sustained throughput: 1 word / OUT_BITS cycles.
//    - First out_valid comes OUT_BITS cycles after RUN entry.
//  RUN persists until start or reset; there is no IDLE return otherwise.
//  start in any state: abort and go to LOAD next edge. out_valid and lockup_fixed clear.
//    The partial word is dropped. start wins over a simultaneous key_valid or out_ready.
//    A key bit in that same cycle is discarded.
//  reset mid-operation: full reset values next edge, regardless of other inputs.
//  out_data is stable while out_valid && !out_ready.
//  Counters are sized clog2(max+1); no wrap occurs inside a phase.
// TESTING
//  Config WIDTH=4, TAP_MASK=4'hC, KEY_LEN=4, WARMUP=0, OUT_BITS=4 unless noted.
//  1 Key 1,0,0,0 on consecutive cycles -> state_o 1,2,4,9; RUN entered;
//    out words 0x9 then 0xA.
//  2 Same key, out_ready=0 for 10 cycles after first out_valid -> out_data=0x9 held.
//    The state freezes at the stall; 0xA arrives 1 cycle after out_ready rises.
//  3 Key 0,0,0,0 -> RUN entered with state_o=1, lockup_fixed=1; the next start clears it.
//  4 Key bits with key_valid gaps of 3 cycles -> same state_o=9 as scenario 1.
//  5 start pulse mid-RUN with out_valid=1 -> next edge: LOAD, state 0, out_valid=0.
//    key_ready=1.
//  6 Default params, WARMUP=64: no out_valid for 64+8 cycles after LOAD exit.
//    reset mid-WARMUP -> IDLE, all outputs 0.

Source files
------------

// File: rtl/lfsr_keystream_gen.sv
// -----------------------------------------------------------------------------
// lfsr_keystream_gen
//
// Fibonacci-LFSR keystream generator for the image-encryption datapath.
// A key is loaded serially by XOR-injecting each bit into the feedback, then
// WARMUP shifts are discarded, then OUT_BITS-wide keystream words are emitted
// to the pixel XOR stage. An all-zero state after loading is repaired to 1.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         pulse: (re)start key load from any state
//   key_bit       serial key bit
//   key_valid     key_bit valid this cycle
//   key_ready     high while the FSM is in LOAD
//   out_data      keystream word, first-generated bit in the MSB
//   out_valid     out_data valid; held until accepted
//   out_ready     consumer accepts when out_valid && out_ready
//   busy          FSM is not IDLE
//   lockup_fixed  sticky: a zero state was repaired since the last start
//   state_o       current LFSR state (s[0] is the newest bit)
//
// Handshakes: a key bit transfers on any cycle with key_valid && key_ready;
// a word transfers on any cycle with out_valid && out_ready. Once out_valid
// is raised, out_data and out_valid stay constant until the transfer cycle.
// -----------------------------------------------------------------------------
module lfsr_keystream_gen #(
    parameter int               WIDTH    = 23,
    parameter logic [WIDTH-1:0] TAP_MASK = 23'h700080,
    parameter int               KEY_LEN  = 64,
    parameter int               WARMUP   = 64,
    parameter int               OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                key_bit,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                lockup_fixed,
    output logic [WIDTH-1:0]    state_o
);

    localparam int KC_W = $clog2(KEY_LEN + 1);
    // A zero-length warmup still needs a legal one-bit counter.
    localparam int WC_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int BC_W = $clog2(OUT_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } fsm_t;

    fsm_t                fsm;
    logic [WIDTH-1:0]    lfsr;
    logic [KC_W-1:0]     key_cnt;
    logic [WC_W-1:0]     warm_cnt;
    logic [BC_W-1:0]     bit_cnt;
    logic [OUT_BITS-1:0] collector;

    logic                fb;
    logic                inj;
    logic [WIDTH-1:0]    shifted;
    logic                last_bit;
    logic                stall;
    logic [OUT_BITS-1:0] word_next;

    always_comb begin
        fb       = ^(lfsr & TAP_MASK);
        inj      = (fsm == ST_LOAD) ? key_bit : 1'b0;
        shifted  = {lfsr[WIDTH-2:0], fb ^ inj};
        last_bit = (bit_cnt == BC_W'(OUT_BITS - 1));
        // A finished word cannot be handed over while the previous one is
        // still waiting, so the whole generator freezes instead.
        stall    = last_bit && out_valid && !out_ready;
        // Output bit is the MSB before the shift; words fill MSB-first.
        word_next    = collector << 1;
        word_next[0] = lfsr[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm          <= ST_IDLE;
            lfsr         <= '0;
            key_cnt      <= '0;
            warm_cnt     <= '0;
            bit_cnt      <= '0;
            collector    <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            lockup_fixed <= 1'b0;
        end else if (start) begin
            // Abort whatever is in flight; any partial word is dropped.
            fsm          <= ST_LOAD;
            lfsr         <= '0;
            key_cnt      <= '0;
            warm_cnt     <= '0;
            bit_cnt      <= '0;
            collector    <= '0;
            out_valid    <= 1'b0;
            lockup_fixed <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                end

                ST_LOAD: begin
                    if (key_valid) begin
                        key_cnt <= key_cnt + KC_W'(1);
                        if (key_cnt == KC_W'(KEY_LEN - 1)) begin
                            // An all-zero state would lock the LFSR forever.
                            if (shifted == '0) begin
                                lfsr         <= WIDTH'(1);
                                lockup_fixed <= 1'b1;
                            end else begin
                                lfsr <= shifted;
                            end
                            fsm <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                        end else begin
                            lfsr <= shifted;
                        end
                    end
                end

                ST_WARMUP: begin
                    lfsr     <= shifted;
                    warm_cnt <= warm_cnt + WC_W'(1);
                    if (warm_cnt == WC_W'(WARMUP - 1)) begin
                        fsm <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!stall) begin
                        lfsr <= shifted;
                        if (last_bit) begin
                            // Also covers accept-and-replace on the same edge.
                            out_data  <= word_next;
                            out_valid <= 1'b1;
                            bit_cnt   <= '0;
                            collector <= '0;
                        end else begin
                            collector <= word_next;
                            bit_cnt   <= bit_cnt + BC_W'(1);
                            if (out_valid && out_ready) begin
                                out_valid <= 1'b0;
                            end
                        end
                    end
                end

                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign key_ready = (fsm == ST_LOAD);
    assign busy      = (fsm != ST_IDLE);
    assign state_o   = lfsr;

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_keystream_gen
//
// Directed bench for lfsr_keystream_gen. Instance dut uses the small
// configuration (WIDTH=4, TAP_MASK=4'hC, KEY_LEN=4, WARMUP=0, OUT_BITS=4) whose
// sequences are worked out by hand; instance dut_d uses the default parameters
// for warmup timing and mid-warmup reset.
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same
// point, i.e. after the edge they were updated by has settled.
// -----------------------------------------------------------------------------
module tb_lfsr_keystream_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small configuration
    logic       reset, start, key_bit, key_valid, out_ready;
    logic       key_ready, out_valid, busy, lockup_fixed;
    logic [3:0] out_data;
    logic [3:0] state_o;

    // default configuration
    logic        d_reset, d_start, d_key_bit, d_key_valid, d_out_ready;
    logic        d_key_ready, d_out_valid, d_busy, d_lockup_fixed;
    logic [7:0]  d_out_data;
    logic [22:0] d_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_keystream_gen #(
        .WIDTH(4), .TAP_MASK(4'hC), .KEY_LEN(4), .WARMUP(0), .OUT_BITS(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .key_bit(key_bit), .key_valid(key_valid), .key_ready(key_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .lockup_fixed(lockup_fixed), .state_o(state_o)
    );

    lfsr_keystream_gen dut_d (
        .clk(clk), .reset(d_reset), .start(d_start),
        .key_bit(d_key_bit), .key_valid(d_key_valid), .key_ready(d_key_ready),
        .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .busy(d_busy), .lockup_fixed(d_lockup_fixed), .state_o(d_state_o)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_key(input logic b);
        key_bit   = b;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] key_a [4];
        logic [3:0] exp_st [4];
        key_a  = '{4'd1, 4'd0, 4'd0, 4'd0};
        exp_st = '{4'h1, 4'h2, 4'h4, 4'h9};

        reset = 1'b1; start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
        out_ready = 1'b0;
        d_reset = 1'b1; d_start = 1'b0; d_key_bit = 1'b0; d_key_valid = 1'b0;
        d_out_ready = 1'b1;
        tick();
        tick();

        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_key_ready", 32'(key_ready), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_lockup", 32'(lockup_fixed), 32'h0);
        reset = 1'b0;
        d_reset = 1'b0;
        tick();
        check("idle_hold_busy", 32'(busy), 32'h0);

        // ---- scenario 1: key 1,0,0,0 -> 1,2,4,9; words 0x9 then 0xA ----
        pulse_start();
        check("s1_load_key_ready", 32'(key_ready), 32'h1);
        check("s1_load_busy", 32'(busy), 32'h1);
        check("s1_load_state", 32'(state_o), 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_key(key_a[i][0]);
            check($sformatf("s1_state_%0d", i), 32'(state_o), 32'(exp_st[i]));
        end
        check("s1_run_key_ready", 32'(key_ready), 32'h0);
        check("s1_run_busy", 32'(busy), 32'h1);
        check("s1_no_lockup", 32'(lockup_fixed), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("s1_early_valid_%0d", i), 32'(out_valid), 32'h0);
        end
        tick();
        check("s1_w0_valid", 32'(out_valid), 32'h1);
        check("s1_w0_data", 32'(out_data), 32'h9);
        tick();
        check("s1_accept_drop", 32'(out_valid), 32'h0);
        tick();
        tick();
        check("s1_gap_valid", 32'(out_valid), 32'h0);
        tick();
        check("s1_w1_valid", 32'(out_valid), 32'h1);
        check("s1_w1_data", 32'(out_data), 32'hA);

        // ---- scenario 2: stall with out_ready low ----
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_key(key_a[i][0]);
        for (int i = 0; i < 4; i++) tick();
        check("s2_w0_valid", 32'(out_valid), 32'h1);
        check("s2_w0_data", 32'(out_data), 32'h9);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("s2_hold_data_%0d", i), 32'(out_data), 32'h9);
            check($sformatf("s2_hold_valid_%0d", i), 32'(out_valid), 32'h1);
        end
        check("s2_frozen_state", 32'(state_o), 32'h7);
        out_ready = 1'b1;
        tick();
        check("s2_w1_valid", 32'(out_valid), 32'h1);
        check("s2_w1_data", 32'(out_data), 32'hA);
        check("s2_resume_state", 32'(state_o), 32'hF);

        // ---- scenario 5: start mid-RUN with out_valid=1, key bit discarded ----
        start = 1'b1; key_valid = 1'b1; key_bit = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; key_valid = 1'b0;
        check("s5_key_ready", 32'(key_ready), 32'h1);
        check("s5_state", 32'(state_o), 32'h0);
        check("s5_out_valid", 32'(out_valid), 32'h0);
        check("s5_busy", 32'(busy), 32'h1);

        // ---- scenario 4: key with 3-cycle key_valid gaps ----
        for (int i = 0; i < 4; i++) begin
            send_key(key_a[i][0]);
            check($sformatf("s4_state_%0d", i), 32'(state_o), 32'(exp_st[i]));
            if (i < 3) begin
                key_bit = ~key_a[i][0];
                for (int g = 0; g < 3; g++) tick();
                check($sformatf("s4_gap_hold_%0d", i), 32'(state_o),
                      32'(exp_st[i]));
            end
        end
        check("s4_run_key_ready", 32'(key_ready), 32'h0);

        // ---- scenario 3: all-zero key -> repaired to 1 ----
        pulse_start();
        for (int i = 0; i < 4; i++) send_key(1'b0);
        check("s3_state", 32'(state_o), 32'h1);
        check("s3_lockup", 32'(lockup_fixed), 32'h1);
        check("s3_run_key_ready", 32'(key_ready), 32'h0);
        tick();
        check("s3_lockup_sticky", 32'(lockup_fixed), 32'h1);
        pulse_start();
        check("s3_lockup_cleared", 32'(lockup_fixed), 32'h0);

        // ---- scenario 6: default params, WARMUP=64, OUT_BITS=8 ----
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        check("s6_key_ready", 32'(d_key_ready), 32'h1);
        d_key_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d_key_bit = ((i % 3) == 0);
            tick();
        end
        d_key_valid = 1'b0;
        check("s6_load_exit_key_ready", 32'(d_key_ready), 32'h0);
        check("s6_load_exit_busy", 32'(d_busy), 32'h1);
        for (int i = 0; i < 71; i++) begin
            tick();
            check($sformatf("s6_no_valid_%0d", i), 32'(d_out_valid), 32'h0);
        end
        tick();
        check("s6_first_valid", 32'(d_out_valid), 32'h1);

        // reset in the middle of warmup beats start/key_valid
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        d_key_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d_key_bit = ((i % 5) == 1);
            tick();
        end
        d_key_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        d_reset = 1'b1; d_start = 1'b1; d_key_valid = 1'b1;
        tick();
        d_reset = 1'b0; d_start = 1'b0; d_key_valid = 1'b0;
        check("s6_rst_busy", 32'(d_busy), 32'h0);
        check("s6_rst_key_ready", 32'(d_key_ready), 32'h0);
        check("s6_rst_out_valid", 32'(d_out_valid), 32'h0);
        check("s6_rst_out_data", 32'(d_out_data), 32'h0);
        check("s6_rst_state", 32'(d_state_o), 32'h0);
        check("s6_rst_lockup", 32'(d_lockup_fixed), 32'h0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
